// File: rtl/fetch_pc_unit.sv
// Program counter and fetch stage: drives the ROM address, picks the next PC,
// captures the returned instruction into the IF register, and halts on bad targets.
module fetch_pc_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0040_0040,
    parameter int                    MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Branch_Taken_i,
    input  logic [DATA_WIDTH-1:0] Branch_Target_i,
    input  logic                  Jalr_i,
    input  logic [DATA_WIDTH-1:0] Jalr_Base_i,
    input  logic [DATA_WIDTH-1:0] Jalr_Offset_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    input  logic                  Fault_Clear_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] PC_Plus_4_o,
    output logic [DATA_WIDTH-1:0] IF_PC_o,
    output logic [DATA_WIDTH-1:0] IF_Instruction_o,
    output logic                  IF_Valid_o,
    output logic                  Fault_o,
    output logic [1:0]            Fault_Cause_o,
    output logic [DATA_WIDTH-1:0] Fault_PC_o,
    output logic [31:0]           Fetch_Count_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] LAST_PC = RESET_PC + DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic                  if_valid_q, if_valid_d;
    logic [1:0]            cause_q, cause_d;
    logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]           count_q, count_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] cand;
    logic                  redirect;
    logic                  misaligned;
    logic                  out_of_range;

    always_comb begin
        pc_plus4     = pc_q + DATA_WIDTH'(4);
        jalr_sum     = Jalr_Base_i + Jalr_Offset_i;
        redirect     = Jalr_i | Branch_Taken_i;
        // JALR has priority over a simultaneous branch.
        if (Jalr_i) begin
            cand = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
        end else if (Branch_Taken_i) begin
            cand = Branch_Target_i;
        end else begin
            cand = pc_plus4;
        end
        misaligned   = (cand[1:0] != 2'b00);
        out_of_range = (cand < RESET_PC) || (cand > LAST_PC);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        cause_d    = cause_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        case (state_q)
            ST_RUN: begin
                if (!Stall_i) begin
                    if (misaligned || out_of_range) begin
                        if_valid_d = 1'b0;
                        fault_pc_d = cand;
                        cause_d    = misaligned ? CAUSE_ALIGN : CAUSE_RANGE;
                        state_d    = ST_FAULT;
                    end else begin
                        pc_d    = cand;
                        if_pc_d = pc_q;
                        if (redirect) begin
                            // Wrong-path slot: the ROM word at pc_q is discarded.
                            if_instr_d = NOP;
                            if_valid_d = 1'b0;
                        end else begin
                            if_instr_d = Instruction_i;
                            if_valid_d = 1'b1;
                            count_d    = count_q + 32'd1;
                        end
                    end
                end
            end
            ST_FAULT: begin
                if (Fault_Clear_i) begin
                    pc_d    = TRAP_VECTOR;
                    cause_d = CAUSE_NONE;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= NOP;
            if_valid_q <= 1'b0;
            cause_q    <= CAUSE_NONE;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            cause_q    <= cause_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign PC_o             = pc_q;
    assign PC_Plus_4_o      = pc_plus4;
    assign IF_PC_o          = if_pc_q;
    assign IF_Instruction_o = if_instr_q;
    assign IF_Valid_o       = if_valid_q;
    assign Fault_o          = (state_q == ST_FAULT);
    assign Fault_Cause_o    = cause_q;
    assign Fault_PC_o       = fault_pc_q;
    assign Fetch_Count_o    = count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; the ROM model returns 0xA0 + word index.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall_i;
    logic        Branch_Taken_i;
    logic [31:0] Branch_Target_i;
    logic        Jalr_i;
    logic [31:0] Jalr_Base_i;
    logic [31:0] Jalr_Offset_i;
    logic [31:0] Instruction_i;
    logic        Fault_Clear_i;
    logic [31:0] PC_o;
    logic [31:0] PC_Plus_4_o;
    logic [31:0] IF_PC_o;
    logic [31:0] IF_Instruction_o;
    logic        IF_Valid_o;
    logic        Fault_o;
    logic [1:0]  Fault_Cause_o;
    logic [31:0] Fault_PC_o;
    logic [31:0] Fetch_Count_o;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit dut (
        .clk              (clk),
        .reset            (reset),
        .Stall_i          (Stall_i),
        .Branch_Taken_i   (Branch_Taken_i),
        .Branch_Target_i  (Branch_Target_i),
        .Jalr_i           (Jalr_i),
        .Jalr_Base_i      (Jalr_Base_i),
        .Jalr_Offset_i    (Jalr_Offset_i),
        .Instruction_i    (Instruction_i),
        .Fault_Clear_i    (Fault_Clear_i),
        .PC_o             (PC_o),
        .PC_Plus_4_o      (PC_Plus_4_o),
        .IF_PC_o          (IF_PC_o),
        .IF_Instruction_o (IF_Instruction_o),
        .IF_Valid_o       (IF_Valid_o),
        .Fault_o          (Fault_o),
        .Fault_Cause_o    (Fault_Cause_o),
        .Fault_PC_o       (Fault_PC_o),
        .Fetch_Count_o    (Fetch_Count_o)
    );

    always #5 clk = ~clk;

    // Combinational ROM stand-in.
    always_comb Instruction_i = 32'h0000_00A0 + ((PC_o - 32'h0040_0000) >> 2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Stall_i         = 1'b0;
        Branch_Taken_i  = 1'b0;
        Branch_Target_i = 32'h0;
        Jalr_i          = 1'b0;
        Jalr_Base_i     = 32'h0;
        Jalr_Offset_i   = 32'h0;
        Fault_Clear_i   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks += 9;
        if (PC_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc got %h exp %h", PC_o, 32'h0040_0000); end
        if (PC_Plus_4_o !== 32'h0040_0004) begin errors++; $display("FAIL reset_pc4 got %h exp %h", PC_Plus_4_o, 32'h0040_0004); end
        if (IF_PC_o !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h exp 0", IF_PC_o); end
        if (IF_Instruction_o !== 32'h13) begin errors++; $display("FAIL reset_if_instr got %h exp 13", IF_Instruction_o); end
        if (IF_Valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IF_Valid_o); end
        if (Fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", Fault_o); end
        if (Fault_Cause_o !== 2'b00) begin errors++; $display("FAIL reset_cause got %b exp 00", Fault_Cause_o); end
        if (Fault_PC_o !== 32'h0) begin errors++; $display("FAIL reset_fault_pc got %h exp 0", Fault_PC_o); end
        if (Fetch_Count_o !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", Fetch_Count_o); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks += 5;
            if (PC_o !== 32'h0040_0000 + 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, PC_o, 32'h0040_0000 + 32'(4 * i)); end
            if (IF_PC_o !== 32'h0040_0000 + 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_if_pc[%0d] got %h", i, IF_PC_o); end
            if (IF_Instruction_o !== 32'hA0 + 32'(i - 1)) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, IF_Instruction_o, 32'hA0 + 32'(i - 1)); end
            if (IF_Valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, IF_Valid_o); end
            if (Fetch_Count_o !== 32'(i)) begin errors++; $display("FAIL seq_count[%0d] got %0d exp %0d", i, Fetch_Count_o, i); end
        end
    endtask

    task automatic test_stall();
        Stall_i         = 1'b1;
        Branch_Taken_i  = 1'b1;
        Branch_Target_i = 32'h0040_0030;
        for (int i = 0; i < 2; i++) begin
            step();
            checks += 4;
            if (PC_o !== 32'h0040_000C) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 0040000c", i, PC_o); end
            if (IF_PC_o !== 32'h0040_0008) begin errors++; $display("FAIL stall_if_pc[%0d] got %h exp 00400008", i, IF_PC_o); end
            if (IF_Instruction_o !== 32'hA2) begin errors++; $display("FAIL stall_instr[%0d] got %h exp a2", i, IF_Instruction_o); end
            if (Fetch_Count_o !== 32'd3) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 3", i, Fetch_Count_o); end
        end
        idle_inputs();
        step();
        checks += 4;
        if (PC_o !== 32'h0040_0010) begin errors++; $display("FAIL stall_resume_pc got %h exp 00400010", PC_o); end
        if (IF_PC_o !== 32'h0040_000C) begin errors++; $display("FAIL stall_resume_if_pc got %h exp 0040000c", IF_PC_o); end
        if (IF_Instruction_o !== 32'hA3) begin errors++; $display("FAIL stall_resume_instr got %h exp a3", IF_Instruction_o); end
        if (Fetch_Count_o !== 32'd4) begin errors++; $display("FAIL stall_resume_count got %0d exp 4", Fetch_Count_o); end
    endtask

    task automatic test_branch();
        idle_inputs();
        do_reset();
        step();
        Branch_Taken_i  = 1'b1;
        Branch_Target_i = 32'h0040_0010;
        step();
        idle_inputs();
        checks += 5;
        if (PC_o !== 32'h0040_0010) begin errors++; $display("FAIL br_pc got %h exp 00400010", PC_o); end
        if (IF_Valid_o !== 1'b0) begin errors++; $display("FAIL br_bubble_valid got %b exp 0", IF_Valid_o); end
        if (IF_Instruction_o !== 32'h13) begin errors++; $display("FAIL br_bubble_instr got %h exp 13", IF_Instruction_o); end
        if (IF_PC_o !== 32'h0040_0004) begin errors++; $display("FAIL br_bubble_if_pc got %h exp 00400004", IF_PC_o); end
        if (Fetch_Count_o !== 32'd1) begin errors++; $display("FAIL br_bubble_count got %0d exp 1", Fetch_Count_o); end
        step();
        checks += 5;
        if (PC_o !== 32'h0040_0014) begin errors++; $display("FAIL br_next_pc got %h exp 00400014", PC_o); end
        if (IF_Valid_o !== 1'b1) begin errors++; $display("FAIL br_target_valid got %b exp 1", IF_Valid_o); end
        if (IF_PC_o !== 32'h0040_0010) begin errors++; $display("FAIL br_target_if_pc got %h exp 00400010", IF_PC_o); end
        if (IF_Instruction_o !== 32'hA4) begin errors++; $display("FAIL br_target_instr got %h exp a4", IF_Instruction_o); end
        if (Fetch_Count_o !== 32'd2) begin errors++; $display("FAIL br_target_count got %0d exp 2", Fetch_Count_o); end
    endtask

    task automatic test_jalr();
        Jalr_i          = 1'b1;
        Jalr_Base_i     = 32'h0040_0021;
        Jalr_Offset_i   = 32'h0000_0003;
        Branch_Taken_i  = 1'b1;
        Branch_Target_i = 32'h0040_0008;
        step();
        idle_inputs();
        checks += 4;
        if (PC_o !== 32'h0040_0024) begin errors++; $display("FAIL jalr_pc got %h exp 00400024", PC_o); end
        if (PC_Plus_4_o !== 32'h0040_0028) begin errors++; $display("FAIL jalr_pc4 got %h exp 00400028", PC_Plus_4_o); end
        if (IF_Valid_o !== 1'b0) begin errors++; $display("FAIL jalr_valid got %b exp 0", IF_Valid_o); end
        if (Fault_o !== 1'b0) begin errors++; $display("FAIL jalr_fault got %b exp 0", Fault_o); end
    endtask

    task automatic test_misaligned();
        Branch_Taken_i  = 1'b1;
        Branch_Target_i = 32'h0040_0006;
        step();
        idle_inputs();
        checks += 6;
        if (Fault_o !== 1'b1) begin errors++; $display("FAIL mis_fault got %b exp 1", Fault_o); end
        if (Fault_Cause_o !== 2'b01) begin errors++; $display("FAIL mis_cause got %b exp 01", Fault_Cause_o); end
        if (Fault_PC_o !== 32'h0040_0006) begin errors++; $display("FAIL mis_fault_pc got %h exp 00400006", Fault_PC_o); end
        if (PC_o !== 32'h0040_0024) begin errors++; $display("FAIL mis_pc_hold got %h exp 00400024", PC_o); end
        if (IF_Valid_o !== 1'b0) begin errors++; $display("FAIL mis_valid got %b exp 0", IF_Valid_o); end
        if (Fetch_Count_o !== 32'd2) begin errors++; $display("FAIL mis_count got %0d exp 2", Fetch_Count_o); end
        // Redirect inputs must be ignored while faulted.
        Branch_Taken_i  = 1'b1;
        Branch_Target_i = 32'h0040_0008;
        step();
        checks += 2;
        if (PC_o !== 32'h0040_0024) begin errors++; $display("FAIL fault_hold_pc got %h exp 00400024", PC_o); end
        if (Fault_o !== 1'b1) begin errors++; $display("FAIL fault_hold got %b exp 1", Fault_o); end
        idle_inputs();
        Fault_Clear_i = 1'b1;
        step();
        idle_inputs();
        checks += 5;
        if (PC_o !== 32'h0040_0040) begin errors++; $display("FAIL clear_pc got %h exp 00400040", PC_o); end
        if (Fault_o !== 1'b0) begin errors++; $display("FAIL clear_fault got %b exp 0", Fault_o); end
        if (Fault_Cause_o !== 2'b00) begin errors++; $display("FAIL clear_cause got %b exp 00", Fault_Cause_o); end
        if (Fault_PC_o !== 32'h0040_0006) begin errors++; $display("FAIL clear_fault_pc got %h exp 00400006", Fault_PC_o); end
        if (IF_Valid_o !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", IF_Valid_o); end
        step();
        checks += 4;
        if (PC_o !== 32'h0040_0044) begin errors++; $display("FAIL trap_next_pc got %h exp 00400044", PC_o); end
        if (IF_PC_o !== 32'h0040_0040) begin errors++; $display("FAIL trap_if_pc got %h exp 00400040", IF_PC_o); end
        if (IF_Instruction_o !== 32'hB0) begin errors++; $display("FAIL trap_instr got %h exp b0", IF_Instruction_o); end
        if (Fetch_Count_o !== 32'd3) begin errors++; $display("FAIL trap_count got %0d exp 3", Fetch_Count_o); end
    endtask

    task automatic test_jalr_misaligned();
        // Only bit 0 is cleared, so bit 1 still faults.
        Jalr_i        = 1'b1;
        Jalr_Base_i   = 32'h0040_0001;
        Jalr_Offset_i = 32'h0000_0001;
        step();
        idle_inputs();
        checks += 2;
        if (Fault_Cause_o !== 2'b01) begin errors++; $display("FAIL jalr_mis_cause got %b exp 01", Fault_Cause_o); end
        if (Fault_PC_o !== 32'h0040_0002) begin errors++; $display("FAIL jalr_mis_fault_pc got %h exp 00400002", Fault_PC_o); end
        Fault_Clear_i = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_below_range();
        idle_inputs();
        do_reset();
        Branch_Taken_i  = 1'b1;
        Branch_Target_i = 32'h003F_FFFC;
        step();
        idle_inputs();
        checks += 3;
        if (Fault_o !== 1'b1) begin errors++; $display("FAIL low_fault got %b exp 1", Fault_o); end
        if (Fault_Cause_o !== 2'b10) begin errors++; $display("FAIL low_cause got %b exp 10", Fault_Cause_o); end
        if (Fault_PC_o !== 32'h003F_FFFC) begin errors++; $display("FAIL low_fault_pc got %h exp 003ffffc", Fault_PC_o); end
    endtask

    task automatic test_out_of_range();
        idle_inputs();
        do_reset();
        for (int i = 0; i < 31; i++) step();
        checks += 3;
        if (PC_o !== 32'h0040_007C) begin errors++; $display("FAIL last_pc got %h exp 0040007c", PC_o); end
        if (Fault_o !== 1'b0) begin errors++; $display("FAIL last_pc_fault got %b exp 0", Fault_o); end
        if (Fetch_Count_o !== 32'd31) begin errors++; $display("FAIL last_pc_count got %0d exp 31", Fetch_Count_o); end
        step();
        checks += 5;
        if (Fault_o !== 1'b1) begin errors++; $display("FAIL oor_fault got %b exp 1", Fault_o); end
        if (Fault_Cause_o !== 2'b10) begin errors++; $display("FAIL oor_cause got %b exp 10", Fault_Cause_o); end
        if (Fault_PC_o !== 32'h0040_0080) begin errors++; $display("FAIL oor_fault_pc got %h exp 00400080", Fault_PC_o); end
        if (PC_o !== 32'h0040_007C) begin errors++; $display("FAIL oor_pc_hold got %h exp 0040007c", PC_o); end
        if (Fetch_Count_o !== 32'd31) begin errors++; $display("FAIL oor_count got %0d exp 31", Fetch_Count_o); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 7;
        if (PC_o !== 32'h0040_0000) begin errors++; $display("FAIL fault_rst_pc got %h exp 00400000", PC_o); end
        if (Fault_o !== 1'b0) begin errors++; $display("FAIL fault_rst_fault got %b exp 0", Fault_o); end
        if (Fault_Cause_o !== 2'b00) begin errors++; $display("FAIL fault_rst_cause got %b exp 00", Fault_Cause_o); end
        if (Fault_PC_o !== 32'h0) begin errors++; $display("FAIL fault_rst_fault_pc got %h exp 0", Fault_PC_o); end
        if (IF_PC_o !== 32'h0) begin errors++; $display("FAIL fault_rst_if_pc got %h exp 0", IF_PC_o); end
        if (IF_Instruction_o !== 32'h13) begin errors++; $display("FAIL fault_rst_instr got %h exp 13", IF_Instruction_o); end
        if (Fetch_Count_o !== 32'h0) begin errors++; $display("FAIL fault_rst_count got %0d exp 0", Fetch_Count_o); end
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        step();
        step();
        Stall_i = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        checks += 3;
        if (PC_o !== 32'h0040_0000) begin errors++; $display("FAIL stall_rst_pc got %h exp 00400000", PC_o); end
        if (IF_Valid_o !== 1'b0) begin errors++; $display("FAIL stall_rst_valid got %b exp 0", IF_Valid_o); end
        if (Fetch_Count_o !== 32'h0) begin errors++; $display("FAIL stall_rst_count got %0d exp 0", Fetch_Count_o); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jalr();
        test_misaligned();
        test_jalr_misaligned();
        test_below_range();
        test_out_of_range();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
